srt4_div_arbiter: RTL and testbench

Shares one SRT-4 divider (8-bit operands, begin/end handshake) between N requesters using round-robin arbitration. Latches the granted client's operands and pulses the divider start. Waits for the divider's done signal and returns quotient/remainder to the granted client. Short-circuits divide-by-zero without using the divider, and recovers from a hung divider with a watchdog that flushes it.

---
 rtl/srt4_div_arbiter_if.sv | 39 +++
 rtl/srt4_div_arbiter.sv | 140 ++++++++++++++
 tb/tb_srt4_div_arbiter.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/srt4_div_arbiter_if.sv
// srt4_div_arbiter_if: client request/response bus plus divider begin/end link.
// slave = arbiter side, master = clients + divider side.
interface srt4_div_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] req_dividend;
  logic [N_REQ*WIDTH-1:0] req_divisor;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]       rsp_quotient;
  logic [WIDTH-1:0]       rsp_remainder;
  logic                   rsp_dbz;
  logic                   rsp_timeout;
  logic                   div_begin;
  logic [WIDTH-1:0]       div_dividend;
  logic [WIDTH-1:0]       div_divisor;
  logic                   div_flush_b;
  logic                   div_end;
  logic [WIDTH-1:0]       div_quotient;
  logic [WIDTH-1:0]       div_remainder;

  modport slave (
    input  req, req_dividend, req_divisor,
    input  div_end, div_quotient, div_remainder,
    output gnt, rsp_valid, rsp_quotient, rsp_remainder,
    output rsp_dbz, rsp_timeout,
    output div_begin, div_dividend, div_divisor, div_flush_b
  );

  modport master (
    output req, req_dividend, req_divisor,
    output div_end, div_quotient, div_remainder,
    input  gnt, rsp_valid, rsp_quotient, rsp_remainder,
    input  rsp_dbz, rsp_timeout,
    input  div_begin, div_dividend, div_divisor, div_flush_b
  );
endinterface

// File: rtl/srt4_div_arbiter.sv
// srt4_div_arbiter: round-robin share of one SRT-4 divider among N_REQ
// clients. Ports: clk, rst_b (async low), bus (slave modport), busy.
module srt4_div_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_b,
  srt4_div_arbiter_if.slave bus,
  output logic              busy
);
  localparam int LW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT, S_ZERO,
    S_FLUSH1, S_FLUSH2, S_RESP
  } state_t;

  state_t           state, nxt;
  logic [LW-1:0]    last, owner, win;
  logic             hit, grant;
  logic [WIDTH-1:0] sel_dvd, sel_dvs;
  logic [WIDTH-1:0] dvd, dvs, q, r;
  logic             dbz, tmo;
  logic [CW-1:0]    cnt;
  int               idx;

  // first requester after the last winner, wrapping
  always_comb begin
    win = '0;
    hit = 1'b0;
    idx = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = int'(last) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!hit && bus.req[LW'(idx)]) begin
        hit = 1'b1;
        win = LW'(idx);
      end
    end
    sel_dvd = WIDTH'(bus.req_dividend >> (int'(win) * WIDTH));
    sel_dvs = WIDTH'(bus.req_divisor >> (int'(win) * WIDTH));
    grant = hit && (state == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt           = state;
    bus.gnt       = '0;
    bus.rsp_valid = '0;
    bus.div_begin = 1'b0;
    bus.div_flush_b = 1'b1;
    busy          = (state != S_IDLE);
    unique case (state)
      S_IDLE: begin
        if (grant) begin
          bus.gnt = N_REQ'(1'b1) << win;
          nxt = (sel_dvs == '0) ? S_ZERO : S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        bus.div_begin = 1'b1;
        nxt = S_WAIT;
      end
      S_WAIT: begin
        // a result on the last allowed cycle still wins
        if (bus.div_end) nxt = S_RESP;
        else if (cnt == CW'(TIMEOUT - 1)) nxt = S_FLUSH1;
      end
      S_ZERO: nxt = S_RESP;
      S_FLUSH1: begin
        bus.div_flush_b = 1'b0;
        nxt = S_FLUSH2;
      end
      S_FLUSH2: begin
        bus.div_flush_b = 1'b0;
        nxt = S_RESP;
      end
      S_RESP: begin
        bus.rsp_valid = N_REQ'(1'b1) << owner;
        nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      last  <= LW'(N_REQ - 1);
      owner <= '0;
      dvd   <= '0;
      dvs   <= '0;
      cnt   <= '0;
      q     <= '0;
      r     <= '0;
      dbz   <= 1'b0;
      tmo   <= 1'b0;
    end else begin
      if (grant) begin
        owner <= win;
        last  <= win;
        dvd   <= sel_dvd;
        dvs   <= sel_dvs;
      end
      if (state == S_LAUNCH)    cnt <= '0;
      else if (state == S_WAIT) cnt <= cnt + 1'b1;
      if (state == S_WAIT && bus.div_end) begin
        q   <= bus.div_quotient;
        r   <= bus.div_remainder;
        dbz <= 1'b0;
        tmo <= 1'b0;
      end
      if (state == S_ZERO) begin
        q   <= '1;
        r   <= dvd;
        dbz <= 1'b1;
        tmo <= 1'b0;
      end
      if (state == S_FLUSH2) begin
        q   <= '0;
        r   <= '0;
        dbz <= 1'b0;
        tmo <= 1'b1;
      end
    end
  end

  assign bus.div_dividend  = dvd;
  assign bus.div_divisor   = dvs;
  assign bus.rsp_quotient  = q;
  assign bus.rsp_remainder = r;
  assign bus.rsp_dbz       = dbz;
  assign bus.rsp_timeout   = tmo;
endmodule

// File: tb/tb_srt4_div_arbiter.sv
// tb_srt4_div_arbiter: directed vectors with a queue scoreboard and
// a behavioural divider with programmable latency (0 = never ends).
module tb_srt4_div_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int T = 10;

  logic clk = 1'b0;
  logic rst_b;
  logic busy;
  always #5 clk = ~clk;

  srt4_div_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

  srt4_div_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(T)) dut (
    .clk  (clk),
    .rst_b(rst_b),
    .bus  (bus),
    .busy (busy)
  );

  typedef struct {
    logic [N-1:0] v;
    logic [W-1:0] a, b, q, r;
    logic         dbz, tmo;
    int           lat, beg, fl;
  } exp_t;

  exp_t         rq[$];
  logic [N-1:0] gq[$];
  int nchk = 0, nerr = 0;
  int cyc = 0, gcyc = 0, nbeg = 0, nfl = 0;
  int div_lat = 6, rem = 0;

  int ta [4] = '{200, 17, 100, 81};
  int tb_[4] = '{9, 5, 7, 9};
  int tq [4] = '{22, 3, 14, 9};
  int tr [4] = '{2, 2, 2, 0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic bad(string nm);
    nchk++;
    nerr++;
    $display("FAIL %s: event missing or unexpected", nm);
  endtask

  function automatic logic [N-1:0] oh(int c);
    return N'(1) << c;
  endfunction

  function automatic exp_t mk(int c, int a, int b, int q, int r,
                              bit dbz, bit tmo, int lat, int beg, int fl);
    exp_t e;
    e.v = oh(c);
    e.a = W'(a);
    e.b = W'(b);
    e.q = W'(q);
    e.r = W'(r);
    e.dbz = dbz;
    e.tmo = tmo;
    e.lat = lat;
    e.beg = beg;
    e.fl = fl;
    return e;
  endfunction

  // divider model: end pulse div_lat cycles after the begin cycle
  always @(negedge clk) begin
    if (!rst_b || !bus.div_flush_b) begin
      rem <= 0;
      bus.div_end <= 1'b0;
    end else if (bus.div_begin) begin
      rem <= div_lat;
      bus.div_end <= 1'b0;
    end else if (rem == 1) begin
      rem <= 0;
      bus.div_end <= 1'b1;
      bus.div_quotient <= bus.div_dividend / bus.div_divisor;
      bus.div_remainder <= bus.div_dividend % bus.div_divisor;
    end else begin
      if (rem > 1) rem <= rem - 1;
      bus.div_end <= 1'b0;
    end
  end

  // monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst_b === 1'b1) begin
      if (bus.div_begin) nbeg <= nbeg + 1;
      if (!bus.div_flush_b) nfl <= nfl + 1;
      if (bus.gnt != '0) begin
        chk("gnt_onehot", 64'($onehot(bus.gnt)), 64'd1);
        chk("gnt_while_busy", 64'(busy), 64'd0);
        if (gq.size() == 0) bad("gnt_unexpected");
        else chk("gnt", 64'(bus.gnt), 64'(gq.pop_front()));
        gcyc <= cyc;
        nbeg <= 0;
        nfl <= 0;
      end
      if (bus.rsp_valid != '0) begin
        if (rq.size() == 0) bad("rsp_unexpected");
        else begin
          e = rq.pop_front();
          chk("rsp_valid", 64'(bus.rsp_valid), 64'(e.v));
          chk("quotient", 64'(bus.rsp_quotient), 64'(e.q));
          chk("remainder", 64'(bus.rsp_remainder), 64'(e.r));
          chk("dbz", 64'(bus.rsp_dbz), 64'(e.dbz));
          chk("timeout", 64'(bus.rsp_timeout), 64'(e.tmo));
          chk("latency", 64'(cyc - gcyc), 64'(e.lat));
          chk("begin_pulses", 64'(nbeg), 64'(e.beg));
          chk("flush_cycles", 64'(nfl), 64'(e.fl));
          chk("div_dividend", 64'(bus.div_dividend), 64'(e.a));
          chk("div_divisor", 64'(bus.div_divisor), 64'(e.b));
        end
      end
    end
  end

  task automatic chk_reset(string nm);
    chk(nm, 64'({bus.gnt, bus.rsp_valid, bus.rsp_quotient,
                 bus.rsp_remainder, bus.rsp_dbz, bus.rsp_timeout,
                 busy, bus.div_begin, bus.div_dividend,
                 bus.div_divisor, bus.div_flush_b}), 64'd1);
  endtask

  task automatic set_op(int c, int a, int b);
    bus.req_dividend[c*W +: W] = W'(a);
    bus.req_divisor[c*W +: W]  = W'(b);
  endtask

  task automatic wait_gnts(int n);
    int seen = 0;
    for (int i = 0; i < 400 && seen < n; i++) begin
      @(negedge clk);
      if (bus.gnt != '0) seen++;
    end
    if (seen < n) bad("gnt_wait_expired");
  endtask

  task automatic drain(int budget);
    int i = 0;
    while ((rq.size() != 0 || busy) && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (rq.size() != 0 || busy) begin
      bad("drain_expired");
      rq.delete();
      gq.delete();
    end
  endtask

  task automatic one(int c, int a, int b, int q, int r,
                     bit dbz, bit tmo, int lat, int beg, int fl);
    @(posedge clk);
    #1;
    set_op(c, a, b);
    gq.push_back(oh(c));
    rq.push_back(mk(c, a, b, q, r, dbz, tmo, lat, beg, fl));
    bus.req[c] = 1'b1;
    wait_gnts(1);
    @(posedge clk);
    #1;
    bus.req[c] = 1'b0;
    drain(100);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_b = 1'b1;
    bus.req = '0;
    bus.req_dividend = '0;
    bus.req_divisor = '0;
    #2 rst_b = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("reset_init");
    rst_b = 1'b1;

    // all four hold req: order 0,1,2,3,0,1
    div_lat = 6;
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) set_op(c, ta[c], tb_[c]);
    for (int k = 0; k < 6; k++) begin
      gq.push_back(oh(k % 4));
      rq.push_back(mk(k % 4, ta[k % 4], tb_[k % 4], tq[k % 4],
                      tr[k % 4], 0, 0, 8, 1, 0));
    end
    bus.req = '1;
    wait_gnts(6);
    @(posedge clk);
    #1;
    bus.req = '0;
    drain(200);

    // client 2 alone, 100/7
    one(2, 100, 7, 14, 2, 0, 0, 8, 1, 0);
    // divide by zero
    one(1, 55, 0, 255, 55, 1, 0, 2, 0, 0);
    // hung divider -> watchdog
    div_lat = 0;
    one(1, 77, 3, 0, 0, 0, 1, T + 4, 1, 2);
    // served normally afterwards
    div_lat = 6;
    one(3, 81, 9, 9, 0, 0, 0, 8, 1, 0);
    // end pulse on the final WAIT cycle
    div_lat = T;
    one(2, 250, 16, 15, 10, 0, 0, T + 2, 1, 0);

    // reset in the middle of WAIT
    div_lat = 0;
    @(posedge clk);
    #1;
    set_op(0, 200, 9);
    gq.push_back(oh(0));
    bus.req[0] = 1'b1;
    wait_gnts(1);
    @(posedge clk);
    #1;
    bus.req[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_b = 1'b0;
    #1 chk_reset("reset_mid");
    repeat (3) @(negedge clk);
    chk_reset("reset_hold");
    rst_b = 1'b1;

    // pointer restored: client 0 wins a 4-way request
    div_lat = 6;
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) set_op(c, ta[c], tb_[c]);
    gq.push_back(oh(0));
    rq.push_back(mk(0, 200, 9, 22, 2, 0, 0, 8, 1, 0));
    bus.req = '1;
    wait_gnts(1);
    @(posedge clk);
    #1;
    bus.req = '0;
    drain(100);
    repeat (3) @(negedge clk);
    if (gq.size() != 0) bad("gnt_queue_leftover");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
